// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic controller family.
//   LAMP_RED / LAMP_YEL / LAMP_GRN : 2-bit lamp codes used on hwy/cnrty buses
//   phase_t                        : phase decoded from one pair of lamp codes
//   decode_phase()                 : maps (hwy, cnrty) to a phase_t
//   max_int()                      : elaboration-time helper for sizing
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b10;

    typedef enum logic [1:0] {
        HG      = 2'd0,   // highway green, cross road red
        CG      = 2'd1,   // cross road green, highway red
        OTHER   = 2'd2,   // yellows and all-red
        ILLEGAL = 2'd3    // code 11 anywhere, or both roads lit at once
    } phase_t;

    function automatic phase_t decode_phase(input logic [1:0] hwy,
                                            input logic [1:0] cnrty);
        phase_t ph;
        ph = OTHER;
        if ((hwy == 2'b11) || (cnrty == 2'b11) ||
            ((hwy != LAMP_RED) && (cnrty != LAMP_RED))) begin
            ph = ILLEGAL;
        end else if ((hwy == LAMP_GRN) && (cnrty == LAMP_RED)) begin
            ph = HG;
        end else if ((hwy == LAMP_RED) && (cnrty == LAMP_GRN)) begin
            ph = CG;
        end
        return ph;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_request_gen_sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
// Two-flop synchroniser followed by a debounce counter for the raw cross-road
// vehicle sensor. The output only changes after the synchronised sensor has
// disagreed with it for DEBOUNCE consecutive cycles.
// Ports:
//   clk         : clock
//   reset       : asynchronous, active-high reset
//   car_raw     : raw sensor, asynchronous to clk
//   car_present : debounced sensor level
// -----------------------------------------------------------------------------
module sensor_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic car_raw,
    output logic car_present
);

    // Counter only needs to reach DEBOUNCE-1: the toggle happens on the cycle
    // that would otherwise bring it to DEBOUNCE.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          car_present_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            car_present_reg <= 1'b0;
            count_reg       <= '0;
        end else begin
            sync1_reg <= car_raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != car_present_reg) begin
                if (count_reg == CW'(DEBOUNCE - 1)) begin
                    car_present_reg <= ~car_present_reg;
                    count_reg       <= '0;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

    assign car_present = car_present_reg;

endmodule

// File: rtl/traffic_request_gen.sv
// -----------------------------------------------------------------------------
// traffic_request_gen
// Request/timing stage in front of traffic_signal_controller. Conditions the
// cross-road sensor, watches the controller's lamp codes to learn the current
// phase, and produces the controller's single request input x while enforcing
// minimum highway green and minimum/maximum cross-road green.
// Ports:
//   clk         : clock
//   reset       : asynchronous, active-high reset
//   car_raw     : raw cross-road sensor (asynchronous)
//   hwy, cnrty  : controller lamp codes fed back (00 red, 01 yellow, 10 green)
//   x           : request to the controller (combinational)
//   car_present : debounced sensor level
//   req_pending : latched cross-road request
//   max_timeout : one-cycle pulse when cross green is cut short by the maximum
//   fault       : sticky flag, illegal lamp code combination observed
// -----------------------------------------------------------------------------
module traffic_request_gen
    import traffic_pkg::*;
#(
    parameter int TICK_DIV      = 1000,
    parameter int DEBOUNCE      = 4,
    parameter int HWY_MIN_GREEN = 10,
    parameter int CNR_MIN_GREEN = 3,
    parameter int CNR_MAX_GREEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_raw,
    input  logic [1:0] hwy,
    input  logic [1:0] cnrty,
    output logic       x,
    output logic       car_present,
    output logic       req_pending,
    output logic       max_timeout,
    output logic       fault
);

    // The timer never needs to count beyond the largest threshold it is
    // compared against; saturating there keeps a long highway green from
    // wrapping back below HWY_MIN_GREEN.
    localparam int TIMER_MAX = max_int(HWY_MIN_GREEN, CNR_MAX_GREEN);
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_reg;
    logic          tick;
    phase_t        phase;
    phase_t        phase_q;
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;
    logic [TW-1:0] elapsed;
    logic          req_pending_reg;
    logic          req_pending_next;
    logic          fault_reg;
    logic          at_max;
    logic          at_max_reg;
    logic          max_timeout_reg;

    sensor_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .car_raw    (car_raw),
        .car_present(car_present)
    );

    // Free-running prescaler; tick marks the wrap cycle.
    assign tick = (pre_reg == PW'(TICK_DIV - 1));

    assign phase = decode_phase(hwy, cnrty);

    // A phase change is seen combinationally, so the first cycle of a new
    // phase already reads elapsed = 0 rather than the previous phase's time.
    assign elapsed = (phase != phase_q) ? '0 : timer_reg;

    always_comb begin
        timer_next = elapsed + TW'(tick);
        if (elapsed >= TW'(TIMER_MAX)) begin
            timer_next = TW'(TIMER_MAX);
        end
    end

    // Entering cross green consumes the request; that takes priority over a
    // car that is still sitting on the sensor.
    always_comb begin
        req_pending_next = req_pending_reg;
        if (phase == CG) begin
            req_pending_next = 1'b0;
        end else if (car_present) begin
            req_pending_next = 1'b1;
        end
    end

    // Elapsed can sit at CNR_MAX_GREEN for several cycles; only the first
    // such cycle may raise max_timeout.
    assign at_max = (phase == CG) && (elapsed == TW'(CNR_MAX_GREEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_reg         <= '0;
            phase_q         <= OTHER;
            timer_reg       <= '0;
            req_pending_reg <= 1'b0;
            fault_reg       <= 1'b0;
            at_max_reg      <= 1'b0;
            max_timeout_reg <= 1'b0;
        end else begin
            pre_reg         <= tick ? '0 : pre_reg + 1'b1;
            phase_q         <= phase;
            timer_reg       <= timer_next;
            req_pending_reg <= req_pending_next;
            fault_reg       <= fault_reg | (phase == ILLEGAL);
            at_max_reg      <= at_max;
            max_timeout_reg <= at_max & ~at_max_reg & car_present;
        end
    end

    always_comb begin
        x = 1'b0;
        if (!fault_reg) begin
            case (phase)
                HG: x = (elapsed >= TW'(HWY_MIN_GREEN)) &
                        (car_present | req_pending_reg);
                CG: x = (elapsed < TW'(CNR_MIN_GREEN)) |
                        (car_present & (elapsed < TW'(CNR_MAX_GREEN)));
                default: x = 1'b0;
            endcase
        end
    end

    assign req_pending = req_pending_reg;
    assign max_timeout = max_timeout_reg;
    assign fault       = fault_reg;

endmodule

// File: doc/traffic_request_gen.md
Name: traffic_request_gen

Overview:
Upstream request/timing stage for traffic_signal_controller; produces its single control input x.
- Conditions the raw cross-road vehicle sensor: synchronise, debounce, latch the request.
- Observes the controller's Hwy/Cnrty lamp codes to learn the current phase.
- Enforces minimum highway green, minimum cross-road green and maximum cross-road green.
- Connection: x drives the controller's x; controller Hwy/Cnrty feed back into hwy/cnrty here.

Parameters:
TICK_DIV, 1000, clk cycles per timing tick (>=1)
DEBOUNCE, 4, consecutive clk cycles the synchronised sensor must differ before car_present changes (>=1)
HWY_MIN_GREEN, 10, ticks highway green is held before a cross request is honoured
CNR_MIN_GREEN, 3, ticks cross-road green is always held
CNR_MAX_GREEN, 8, ticks after which cross-road green is released even with a car present (> CNR_MIN_GREEN)

Ports:
clk  in  1  clock
reset  in  1  reset
car_raw  in  1  raw cross-road sensor, asynchronous to clk
hwy  in  2  controller highway lamp code (00 red, 01 yellow, 10 green)
cnrty  in  2  controller cross-road lamp code (same encoding)
x  out  1  controller transition/hold request
car_present  out  1  debounced sensor level
req_pending  out  1  latched cross-road request
max_timeout  out  1  one-cycle pulse: cross green ended by CNR_MAX_GREEN with a car still present
fault  out  1  sticky illegal-lamp-code flag

Behaviour:
- Reset: clk; reset is asynchronous, active-high. Reset clears car_present, req_pending, max_timeout, fault, the synchroniser, debounce, prescaler and phase timer to 0. Stored phase is set to OTHER.
- Synchroniser: 2 flops on car_raw. Debounce counter counts while the synced value differs from car_present. It clears whenever they match. When the count reaches DEBOUNCE, car_present toggles and the counter clears. Latency from a clean edge on car_raw = 2 + DEBOUNCE cycles.
- Prescaler: free-running counter 0..TICK_DIV-1; tick is high on the wrap cycle. TICK_DIV=1 gives tick every cycle.
- Phase decode (combinational):
  - HG: hwy=10, cnrty=00.
  - CG: hwy=00, cnrty=10.
  - ILLEGAL: either code is 11, or both codes are non-00.
  - OTHER: anything else.
  - Registered as phase_q each cycle.
- Phase timer:
  - elapsed = 0 on any cycle where phase != phase_q.
  - Otherwise elapsed = the registered timer.
  - Register loads elapsed + tick, saturating at max(HWY_MIN_GREEN, CNR_MAX_GREEN).
- req_pending:
  - Sets on a cycle where car_present=1 and phase is not CG.
  - Clears on a cycle where phase is CG.
  - Clear wins over set.
- x (combinational from registered state and the current hwy/cnrty, so the controller sees a valid value on the first cycle of every phase):
  - HG: x = (elapsed >= HWY_MIN_GREEN) & (car_present | req_pending).
  - CG: x = (elapsed < CNR_MIN_GREEN) | (car_present & elapsed < CNR_MAX_GREEN).
  - OTHER, ILLEGAL, or fault=1: x = 0.
- max_timeout: registered pulse. Set for one cycle after a CG cycle where car_present=1 and elapsed first equals CNR_MAX_GREEN.
- fault:
  - Sets the cycle after ILLEGAL is decoded; holds until reset.
  - While fault=1, x=0 and req_pending still tracks.
- Boundaries:
  - A sensor edge during yellow/all-red is not lost; it is held in req_pending.
  - A car leaving before the highway minimum still leaves req_pending set.
  - Reset mid-phase restarts all timing.
  - Timer saturation prevents wrap-around during a long highway green.

Decomposition:
- Shared package traffic_pkg: lamp-code constants (LAMP_RED=00, LAMP_YEL=01, LAMP_GRN=10) and phase enum (HG, CG, OTHER, ILLEGAL). The controller is updated later to use it.
- One natural sub-module: sensor_debounce (synchroniser plus debounce counter, parameter DEBOUNCE), outputs car_present.

Test Plan:
All scenarios use TICK_DIV=2, DEBOUNCE=3, HWY_MIN_GREEN=4, CNR_MIN_GREEN=2, CNR_MAX_GREEN=5, with the controller instanced in loop.
- Reset, car_raw=0 for 100 cycles -> x=0 throughout, controller stays hwy=10; all outputs 0.
- car_raw rises at cycle 20 -> car_present=1 at cycle 25. x=1 when HG elapsed reaches 4 (8 cycles into HG). Controller then goes 10→01→00→ cnrty=10.
- car_raw glitch high for 2 cycles -> car_present stays 0, req_pending 0, x 0.
- Car pulse of 6 cycles while highway is yellow -> req_pending=1. Next HG honours it at elapsed=4; req_pending clears on CG entry.
- Car held continuously -> CG lasts until elapsed=5 (10 cycles); max_timeout pulses once; x drops; cnrty goes to 01.
- Force hwy=10, cnrty=10 for 1 cycle -> fault=1 next cycle, x=0, fault persists until reset.
